// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N_CH-to-1 valid/ready stream multiplexer with a single output
// register. Channel choice is either an external index (mode=0) or a
// round-robin scan starting after the most recently granted channel (mode=1).
module stream_mux_rr #(
    parameter  int N_CH = 4,
    parameter  int W    = 4,
    localparam int SW   = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [SW-1:0]     sel,
    input  logic [N_CH-1:0]   in_valid,
    input  logic [N_CH*W-1:0] in_data,
    output logic [N_CH-1:0]   in_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [SW-1:0]     out_ch,
    input  logic              out_ready
);

    logic [SW-1:0] ptr;
    logic [SW-1:0] rr_cand;
    logic [SW-1:0] grant_idx;
    logic          grant_any;
    logic [W-1:0]  grant_data;
    logic          can_load;
    logic          ch_xfer;

    // The output register may take a new word when empty or draining this cycle;
    // reset blocks every channel so nothing is consumed while rst is high.
    assign can_load = !out_valid || out_ready;
    assign ch_xfer  = !rst && can_load && grant_any;

    // Pick the granted channel: the selected one if valid, or the first valid
    // channel found scanning forward from the one after ptr.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        rr_cand   = '0;
        if (mode == 1'b0) begin
            for (int i = 0; i < N_CH; i++) begin
                if (sel == SW'(i) && in_valid[i]) begin
                    grant_any = 1'b1;
                    grant_idx = SW'(i);
                end
            end
        end else begin
            for (int k = 1; k <= N_CH; k++) begin
                rr_cand = SW'((int'(ptr) + k) % N_CH);
                if (!grant_any && in_valid[rr_cand]) begin
                    grant_any = 1'b1;
                    grant_idx = rr_cand;
                end
            end
        end
    end

    // Route the granted channel's data toward the output register.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant_idx == SW'(i)) begin
                grant_data = in_data[i*W +: W];
            end
        end
    end

    // Raise ready only on the granted channel, and only when it can actually transfer.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_xfer && grant_idx == SW'(i)) begin
                in_ready[i] = 1'b1;
            end
        end
    end

    // Output register and round-robin pointer; a load takes priority over a
    // plain drain so back-to-back words flow at one per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= SW'(N_CH - 1);
        end else if (ch_xfer) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_ch    <= grant_idx;
            ptr       <= grant_idx;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed-vector bench for stream_mux_rr. A 4-channel
// instance covers the main behaviour; a 3-channel instance covers the
// out-of-range external select.
module tb_stream_mux_rr;

    logic        clk;
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [15:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [3:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_ready;

    logic        rst3;
    logic        mode3;
    logic [1:0]  sel3;
    logic [2:0]  in_valid3;
    logic [11:0] in_data3;
    logic [2:0]  in_ready3;
    logic        out_valid3;
    logic [3:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_ready3;

    int total;
    int bad;

    stream_mux_rr #(.N_CH(4), .W(4)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
        .out_ready(out_ready)
    );

    stream_mux_rr #(.N_CH(3), .W(4)) dut3 (
        .clk(clk), .rst(rst3), .mode(mode3), .sel(sel3),
        .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_data(out_data3), .out_ch(out_ch3),
        .out_ready(out_ready3)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b1; sel = 2'd0; in_valid = 4'hF;
        in_data = 16'hDA53; out_ready = 1'b1;
        tick();
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%0h exp=0", out_valid); end
        total++; if (out_data !== 4'h0) begin bad++; $display("[TB] FAIL reset_data got=%0h exp=0", out_data); end
        total++; if (out_ch !== 2'd0) begin bad++; $display("[TB] FAIL reset_ch got=%0h exp=0", out_ch); end
        total++; if (in_ready !== 4'b0000) begin bad++; $display("[TB] FAIL reset_in_ready got=%b exp=0000", in_ready); end
    endtask

    task automatic test_ext_select();
        rst = 1'b0; mode = 1'b0; sel = 2'd2; in_valid = 4'hF;
        in_data = 16'hDA53; out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 4'b0100) begin bad++; $display("[TB] FAIL ext_in_ready got=%b exp=0100", in_ready); end
        for (int c = 0; c < 3; c++) begin
            tick();
            total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL ext_valid[%0d] got=%0h exp=1", c, out_valid); end
            total++; if (out_data !== 4'hA) begin bad++; $display("[TB] FAIL ext_data[%0d] got=%0h exp=a", c, out_data); end
            total++; if (out_ch !== 2'd2) begin bad++; $display("[TB] FAIL ext_ch[%0d] got=%0d exp=2", c, out_ch); end
            total++; if (in_ready !== 4'b0100) begin bad++; $display("[TB] FAIL ext_ready[%0d] got=%b exp=0100", c, in_ready); end
        end
    endtask

    task automatic test_rr_all();
        int         exp_ch [6] = '{0, 1, 2, 3, 0, 1};
        logic [3:0] val    [4] = '{4'h3, 4'h5, 4'hA, 4'hD};
        rst = 1'b1;
        tick();
        rst = 1'b0; mode = 1'b1; in_valid = 4'hF; in_data = 16'hDA53; out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 4'b0001) begin bad++; $display("[TB] FAIL rr_first_ready got=%b exp=0001", in_ready); end
        for (int c = 0; c < 6; c++) begin
            tick();
            total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL rr_valid[%0d] got=%0h exp=1", c, out_valid); end
            total++; if (out_ch !== 2'(exp_ch[c])) begin bad++; $display("[TB] FAIL rr_ch[%0d] got=%0d exp=%0d", c, out_ch, exp_ch[c]); end
            total++; if (out_data !== val[exp_ch[c]]) begin bad++; $display("[TB] FAIL rr_data[%0d] got=%0h exp=%0h", c, out_data, val[exp_ch[c]]); end
        end
    endtask

    task automatic test_rr_skip();
        int         seq_a [4] = '{1, 3, 1, 3};
        int         seq_b [3] = '{0, 1, 3};
        logic [3:0] val   [4] = '{4'h3, 4'h5, 4'hA, 4'hD};
        rst = 1'b1;
        tick();
        rst = 1'b0; mode = 1'b1; in_valid = 4'b1010; in_data = 16'hDA53; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            total++; if (out_ch !== 2'(seq_a[c])) begin bad++; $display("[TB] FAIL skip_ch[%0d] got=%0d exp=%0d", c, out_ch, seq_a[c]); end
        end
        in_valid = 4'b1011;
        #1;
        total++; if (in_ready !== 4'b0001) begin bad++; $display("[TB] FAIL skip_wrap_ready got=%b exp=0001", in_ready); end
        for (int c = 0; c < 3; c++) begin
            tick();
            total++; if (out_ch !== 2'(seq_b[c])) begin bad++; $display("[TB] FAIL skip2_ch[%0d] got=%0d exp=%0d", c, out_ch, seq_b[c]); end
            total++; if (out_data !== val[seq_b[c]]) begin bad++; $display("[TB] FAIL skip2_data[%0d] got=%0h exp=%0h", c, out_data, val[seq_b[c]]); end
        end
    endtask

    task automatic test_backpressure();
        rst = 1'b1;
        tick();
        rst = 1'b0; mode = 1'b1; in_valid = 4'hF; in_data = 16'h4271; out_ready = 1'b1;
        tick();
        tick();
        total++; if (out_ch !== 2'd1) begin bad++; $display("[TB] FAIL bp_load_ch got=%0d exp=1", out_ch); end
        total++; if (out_data !== 4'h7) begin bad++; $display("[TB] FAIL bp_load_data got=%0h exp=7", out_data); end
        out_ready = 1'b0;
        #1;
        total++; if (in_ready !== 4'b0000) begin bad++; $display("[TB] FAIL bp_ready got=%b exp=0000", in_ready); end
        for (int c = 0; c < 3; c++) begin
            tick();
            total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid[%0d] got=%0h exp=1", c, out_valid); end
            total++; if (out_data !== 4'h7) begin bad++; $display("[TB] FAIL bp_data[%0d] got=%0h exp=7", c, out_data); end
            total++; if (out_ch !== 2'd1) begin bad++; $display("[TB] FAIL bp_ch[%0d] got=%0d exp=1", c, out_ch); end
            total++; if (in_ready !== 4'b0000) begin bad++; $display("[TB] FAIL bp_hold_ready[%0d] got=%b exp=0000", c, in_ready); end
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 4'b0100) begin bad++; $display("[TB] FAIL bp_release_ready got=%b exp=0100", in_ready); end
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_next_valid got=%0h exp=1", out_valid); end
        total++; if (out_ch !== 2'd2) begin bad++; $display("[TB] FAIL bp_next_ch got=%0d exp=2", out_ch); end
        total++; if (out_data !== 4'h2) begin bad++; $display("[TB] FAIL bp_next_data got=%0h exp=2", out_data); end
    endtask

    task automatic test_out_of_range();
        rst3 = 1'b1; mode3 = 1'b0; sel3 = 2'd1; in_valid3 = 3'b111;
        in_data3 = 12'h987; out_ready3 = 1'b0;
        tick();
        rst3 = 1'b0;
        #1;
        total++; if (in_ready3 !== 3'b010) begin bad++; $display("[TB] FAIL oor_sel1_ready got=%b exp=010", in_ready3); end
        tick();
        total++; if (out_valid3 !== 1'b1) begin bad++; $display("[TB] FAIL oor_load_valid got=%0h exp=1", out_valid3); end
        total++; if (out_data3 !== 4'h8) begin bad++; $display("[TB] FAIL oor_load_data got=%0h exp=8", out_data3); end
        total++; if (out_ch3 !== 2'd1) begin bad++; $display("[TB] FAIL oor_load_ch got=%0d exp=1", out_ch3); end
        sel3 = 2'd3; out_ready3 = 1'b1;
        #1;
        total++; if (in_ready3 !== 3'b000) begin bad++; $display("[TB] FAIL oor_ready got=%b exp=000", in_ready3); end
        tick();
        total++; if (out_valid3 !== 1'b0) begin bad++; $display("[TB] FAIL oor_drain_valid got=%0h exp=0", out_valid3); end
        total++; if (in_ready3 !== 3'b000) begin bad++; $display("[TB] FAIL oor_drain_ready got=%b exp=000", in_ready3); end
        total++; if (out_data3 !== 4'h8) begin bad++; $display("[TB] FAIL oor_hold_data got=%0h exp=8", out_data3); end
        tick();
        total++; if (out_valid3 !== 1'b0) begin bad++; $display("[TB] FAIL oor_idle_valid got=%0h exp=0", out_valid3); end
    endtask

    task automatic test_reset_mid();
        rst = 1'b0; mode = 1'b1; in_valid = 4'hF; in_data = 16'hDA53; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL mid_pre_valid got=%0h exp=1", out_valid); end
        rst = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_valid got=%0h exp=0", out_valid); end
        total++; if (out_data !== 4'h0) begin bad++; $display("[TB] FAIL mid_data got=%0h exp=0", out_data); end
        total++; if (out_ch !== 2'd0) begin bad++; $display("[TB] FAIL mid_ch got=%0d exp=0", out_ch); end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 4'b0000) begin bad++; $display("[TB] FAIL mid_rst_ready got=%b exp=0000", in_ready); end
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 4'b0001) begin bad++; $display("[TB] FAIL mid_release_ready got=%b exp=0001", in_ready); end
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL mid_first_valid got=%0h exp=1", out_valid); end
        total++; if (out_ch !== 2'd0) begin bad++; $display("[TB] FAIL mid_first_ch got=%0d exp=0", out_ch); end
        total++; if (out_data !== 4'h3) begin bad++; $display("[TB] FAIL mid_first_data got=%0h exp=3", out_data); end
    endtask

    // Run every scenario in order, then report the totals.
    initial begin
        total = 0;
        bad   = 0;
        rst3 = 1'b1; mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b000;
        in_data3 = 12'h000; out_ready3 = 1'b0;
        test_reset();
        test_ext_select();
        test_rr_all();
        test_rr_skip();
        test_backpressure();
        test_out_of_range();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 Parameter N_CH, default 4, number of input channels, legal range 2..16.
REQ-002 Parameter W, default 4, data width in bits per channel, legal range >= 1.
REQ-003 Derived SW = $clog2(N_CH), the width of the channel index.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 mode  in  1  channel selection mode:
  - 0 = external select.
  - 1 = round-robin.
REQ-007 sel  in  SW  channel index, used only when mode=0.
REQ-008 in_valid  in  N_CH  per-channel valid.
REQ-009 in_data  in  N_CH*W  packed channel data; channel i occupies bits [i*W +: W].
REQ-010 in_ready  out  N_CH  per-channel ready.
REQ-011 out_valid  out  1  output word valid.
REQ-012 out_data  out  W  output word.
REQ-013 out_ch  out  SW  index of the channel that supplied out_data.
REQ-014 out_ready  in  1  downstream ready.

Function
REQ-015 Transfer rules:
  - A channel transfer occurs when in_valid[i] and in_ready[i] are both high at a clock edge.
  - An output transfer occurs when out_valid and out_ready are both high at a clock edge.
REQ-016 Output stage is one register; "can_load" = !out_valid || out_ready.
REQ-017 At most one bit of in_ready shall be high in any cycle.
REQ-018 in_ready[i] = can_load && grant[i]; in_ready is combinational from out_ready, mode, sel, in_valid and the RR pointer.
REQ-019 mode=0 grant:
  - grant[sel] = 1 only if sel < N_CH and in_valid[sel] = 1.
  - All other channels are not granted.
  - sel >= N_CH grants nothing; no transfer occurs and no error is raised.
REQ-020 mode=1 grant: scan channels in order ptr+1, ptr+2, ... (modulo N_CH) and grant the first with in_valid=1; ptr is the last granted channel.
REQ-021 ptr updates to the granted index only on a channel transfer; in mode=0 a transfer also sets ptr := sel.
REQ-022 On a channel transfer from i, at the same edge:
  - out_data := in_data[i].
  - out_ch := i.
  - out_valid := 1.
REQ-023 On an output transfer with no channel transfer at the same edge, out_valid := 0; out_data and out_ch hold their values.
REQ-024 Simultaneous output transfer and channel transfer: the register reloads and out_valid stays 1, giving full throughput of 1 word/cycle.
REQ-025 Latency: a word accepted at edge k is presented on out_* from edge k until its output transfer.
REQ-026 Backpressure: while out_valid=1 and out_ready=0:
  - all in_ready are 0;
  - out_data and out_ch hold stable;
  - ptr holds.
REQ-027 No input valid (or nothing granted): out_valid falls after the pending word drains; ptr unchanged.
REQ-028 A mode or sel change takes effect combinationally in the same cycle; a word already in the output register is never altered or dropped.
REQ-029 Words are never duplicated or lost; each channel transfer produces exactly one output transfer.
REQ-030 Fairness: in mode=1 with all N_CH channels continuously valid and out_ready=1, each channel is granted exactly once in every N_CH consecutive transfers.

Reset
REQ-031 While rst=1 at a clock edge:
  - out_valid := 0, out_data := 0, out_ch := 0;
  - ptr := N_CH-1, so channel 0 has highest priority after reset.
REQ-032 While rst=1, all in_ready shall be 0 regardless of other inputs.
REQ-033 Reset asserted mid-operation discards any held output word; no output transfer of it occurs afterwards.
REQ-034 The first edge with rst=0 may accept a word.

Verification
REQ-035 External select (N_CH=4, W=4, mode=0, sel=2):
  - Stimulus: in_data = {d3=4'hD, d2=4'hA, d1=4'h5, d0=4'h3}, all valid, out_ready=1.
  - Response: in_ready=4'b0100; next cycle out_valid=1, out_data=4'hA, out_ch=2; sustained every cycle.
REQ-036 Round-robin, all valid (mode=1, out_ready=1, from reset):
  - Response: out_ch sequence 0,1,2,3,0,1 on consecutive cycles; out_data tracks each channel's in_data.
REQ-037 Round-robin skip (mode=1, in_valid=4'b1010):
  - Response: out_ch alternates 1,3,1,3.
  - Then raise in_valid[0]: the next grant follows ptr order (after 3 comes 0).
REQ-038 Backpressure: hold out_ready=0 for 3 cycles with a word 4'h7 from ch1 held.
  - Response: out_data=4'h7, out_ch=1 stable; in_ready=0.
  - Release: the word transfers once; the next grant is ch2 (mode=1, all valid).
REQ-039 Out-of-range select (N_CH=3, mode=0, sel=3, all valid):
  - Response: in_ready=0; out_valid drops after the pending word drains.
REQ-040 Reset mid-operation: assert rst with out_valid=1, out_ready=0.
  - Response: next cycle out_valid=0, out_data=0, out_ch=0.
  - After release (mode=1, all valid): first out_ch=0.
